// File: rtl/cp0_exc_unit_pkg.sv
// rtl/cp0_exc_unit_pkg.sv - CP0 register numbers, ExcCodes, Status/Cause field indices
package cp0_exc_unit_pkg;

    // CP0 register numbers (rd field of MFC0/MTC0)
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;

    typedef enum logic [4:0] {
        EXC_INT  = 5'h00,
        EXC_ADEL = 5'h04,
        EXC_ADES = 5'h05,
        EXC_SYS  = 5'h08,
        EXC_BP   = 5'h09,
        EXC_RI   = 5'h0A,
        EXC_OV   = 5'h0C
    } exc_code_e;

    // Status field indices
    localparam int ST_IE    = 0;
    localparam int ST_EXL   = 1;
    localparam int ST_IM_LO = 8;
    localparam int ST_IM_HI = 15;

    // Cause field indices
    localparam int CA_EXC_LO = 2;
    localparam int CA_EXC_HI = 6;
    localparam int CA_SW_LO  = 8;   // IP[1:0], software interrupts
    localparam int CA_SW_HI  = 9;
    localparam int CA_HW_LO  = 10;  // IP[7:2], sampled every cycle
    localparam int CA_IP_LO  = 8;
    localparam int CA_IP_HI  = 15;
    localparam int CA_BD     = 31;

    // Bits an MTC0 may change
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    // Register value as it reads after an MTC0 of wdata through mask
    function automatic logic [31:0] wmerge(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [31:0] mask);
        return (old_val & ~mask) | (wdata & mask);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - Count/Compare timer with half-rate tick and pending flag
// Ports: clk, rst (sync, active-high); count_we/compare_we gated MTC0 strobes;
//        wdata MTC0 data; count_o, compare_o, pending_o live state.
module cp0_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        pending_o
);

    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic        tick_q;
    logic        pending_q;
    logic [31:0] count_nxt;
    logic        count_moves;

    // Count advances on every second edge (tick_q high); a Count write
    // also counts as a change so a load that lands on Compare raises pending.
    always_comb begin
        count_moves = count_we | tick_q;
        count_nxt   = count_q;
        if (count_we) begin
            count_nxt = wdata;
        end else if (tick_q) begin
            count_nxt = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            compare_q <= '0;
            tick_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            count_q <= count_nxt;
            tick_q  <= count_we ? 1'b0 : ~tick_q;
            if (compare_we) begin
                compare_q <= wdata;
            end
            if (compare_we) begin
                pending_q <= 1'b0;
            end else if (count_moves && (count_nxt == compare_q) && (compare_q != 32'd0)) begin
                pending_q <= 1'b1;
            end
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign pending_o = pending_q;

endmodule

// File: rtl/cp0_exc_unit.sv
// rtl/cp0_exc_unit.sv - CP0 register file and exception/ERET arbiter at M/W
// Option macro: COUNT_TIMER_EN (Count/Compare timer; absent -> Count/Compare read 0).
// Ports: clk, rst (sync, active-high); we_i/waddr_i/wdata_i MTC0; raddr_i/rdata_o MFC0;
//        hw_int_i interrupt lines; pc_i, in_delayslot_i and exception flags of the
//        M instruction; bad_addr_i faulting data address; flush_o/newpc_o redirect;
//        status_o, cause_o, epc_o live registers; timer_int_o timer pending.
module cp0_exc_unit
    import cp0_exc_unit_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter logic [31:0] STATUS_RST = 32'h0040_FF00,
    parameter logic [31:0] PRID_VAL   = 32'h0000_4220
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] rdata_o,
    input  logic [5:0]  hw_int_i,
    input  logic [31:0] pc_i,
    input  logic        in_delayslot_i,
    input  logic        syscall_i,
    input  logic        break_i,
    input  logic        reserve_i,
    input  logic        eret_i,
    input  logic        ov_i,
    input  logic        adel_if_i,
    input  logic        adel_i,
    input  logic        ades_i,
    input  logic [31:0] bad_addr_i,
    output logic        flush_o,
    output logic [31:0] newpc_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic        timer_int_o
);

    logic [31:0] status_q;
    logic [31:0] cause_q;
    logic [31:0] epc_q;
    logic [31:0] badvaddr_q;

    logic [31:0] count_w;
    logic [31:0] compare_w;
    logic        timer_pending_w;

    logic        int_req;
    logic        exc_taken;
    logic        eret_taken;
    exc_code_e   exc_code;
    logic        badv_we;
    logic [31:0] badv_val;
    logic        mtc0_en;

    // ------------------------------------------------------------------
    // Exception arbiter: fixed priority, interrupt first
    // ------------------------------------------------------------------
    always_comb begin
        int_req = status_q[ST_IE] & ~status_q[ST_EXL]
                & (|(cause_q[CA_IP_HI:CA_IP_LO] & status_q[ST_IM_HI:ST_IM_LO]));
        exc_taken = 1'b1;
        exc_code  = EXC_INT;
        badv_we   = 1'b0;
        badv_val  = bad_addr_i;
        if (int_req) begin
            exc_code = EXC_INT;
        end else if (adel_if_i) begin
            exc_code = EXC_ADEL;
            badv_we  = 1'b1;
            badv_val = pc_i;
        end else if (syscall_i) begin
            exc_code = EXC_SYS;
        end else if (break_i) begin
            exc_code = EXC_BP;
        end else if (reserve_i) begin
            exc_code = EXC_RI;
        end else if (ov_i) begin
            exc_code = EXC_OV;
        end else if (adel_i) begin
            exc_code = EXC_ADEL;
            badv_we  = 1'b1;
        end else if (ades_i) begin
            exc_code = EXC_ADES;
            badv_we  = 1'b1;
        end else begin
            exc_taken = 1'b0;
        end
    end

    assign eret_taken = eret_i & ~exc_taken;
    assign flush_o    = exc_taken | eret_taken;
    assign newpc_o    = exc_taken ? EXC_VECTOR : epc_q;
    // A redirecting cycle squashes the MTC0 in M along with everything else
    assign mtc0_en    = we_i & ~flush_o;

    // ------------------------------------------------------------------
    // Count/Compare timer
    // ------------------------------------------------------------------
`ifdef COUNT_TIMER_EN
    localparam logic [31:0] TIMER_WMASK = 32'hFFFF_FFFF;

    logic count_we;
    logic compare_we;

    assign count_we   = mtc0_en && (waddr_i == CP0_COUNT);
    assign compare_we = mtc0_en && (waddr_i == CP0_COMPARE);

    cp0_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (count_we),
        .compare_we (compare_we),
        .wdata      (wdata_i),
        .count_o    (count_w),
        .compare_o  (compare_w),
        .pending_o  (timer_pending_w)
    );
`else
    localparam logic [31:0] TIMER_WMASK = 32'h0000_0000;

    assign count_w         = '0;
    assign compare_w       = '0;
    assign timer_pending_w = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q   <= STATUS_RST;
            cause_q    <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else begin
            // Timer folds onto the top hardware line
            cause_q[CA_IP_HI:CA_HW_LO] <= {hw_int_i[5] | timer_pending_w, hw_int_i[4:0]};
            if (exc_taken) begin
                status_q[ST_EXL]              <= 1'b1;
                cause_q[CA_EXC_HI:CA_EXC_LO]  <= exc_code;
                // Nested exception keeps the original return point
                if (!status_q[ST_EXL]) begin
                    epc_q          <= in_delayslot_i ? (pc_i - 32'd4) : pc_i;
                    cause_q[CA_BD] <= in_delayslot_i;
                end
                if (badv_we) begin
                    badvaddr_q <= badv_val;
                end
            end else if (eret_taken) begin
                status_q[ST_EXL] <= 1'b0;
            end else if (mtc0_en) begin
                case (waddr_i)
                    CP0_STATUS: status_q <= wmerge(status_q, wdata_i, STATUS_WMASK);
                    CP0_CAUSE:  cause_q[CA_SW_HI:CA_SW_LO] <= wdata_i[CA_SW_HI:CA_SW_LO];
                    CP0_EPC:    epc_q <= wdata_i;
                    default:    ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // MFC0 read with same-cycle MTC0 bypass
    // ------------------------------------------------------------------
    logic [31:0] rd_raw;
    logic [31:0] rd_mask;

    always_comb begin
        rd_raw  = '0;
        rd_mask = '0;
        case (raddr_i)
            CP0_BADVADDR: rd_raw = badvaddr_q;
            CP0_COUNT:    begin rd_raw = count_w;   rd_mask = TIMER_WMASK;  end
            CP0_COMPARE:  begin rd_raw = compare_w; rd_mask = TIMER_WMASK;  end
            CP0_STATUS:   begin rd_raw = status_q;  rd_mask = STATUS_WMASK; end
            CP0_CAUSE:    begin rd_raw = cause_q;   rd_mask = CAUSE_WMASK;  end
            CP0_EPC:      begin rd_raw = epc_q;     rd_mask = 32'hFFFF_FFFF; end
            CP0_PRID:     rd_raw = PRID_VAL;
            default:      rd_raw = '0;
        endcase
        rdata_o = rd_raw;
        if (we_i && (waddr_i == raddr_i)) begin
            rdata_o = wmerge(rd_raw, wdata_i, rd_mask);
        end
    end

    assign status_o    = status_q;
    assign cause_o     = cause_q;
    assign epc_o       = epc_q;
    assign timer_int_o = timer_pending_w;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// tb/tb_cp0_exc_unit.sv - self-checking bench for cp0_exc_unit against a field-level model
module tb_cp0_exc_unit;

`ifdef COUNT_TIMER_EN
    localparam bit TIMER_EN = 1'b1;
`else
    localparam bit TIMER_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [31:0] rdata_o;
    logic [5:0]  hw_int_i;
    logic [31:0] pc_i;
    logic        in_delayslot_i;
    logic        syscall_i, break_i, reserve_i, eret_i, ov_i;
    logic        adel_if_i, adel_i, ades_i;
    logic [31:0] bad_addr_i;
    logic        flush_o;
    logic [31:0] newpc_o;
    logic [31:0] status_o, cause_o, epc_o;
    logic        timer_int_o;

    always #5 clk = ~clk;

    cp0_exc_unit dut (
        .clk(clk), .rst(rst),
        .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .raddr_i(raddr_i), .rdata_o(rdata_o),
        .hw_int_i(hw_int_i), .pc_i(pc_i), .in_delayslot_i(in_delayslot_i),
        .syscall_i(syscall_i), .break_i(break_i), .reserve_i(reserve_i), .eret_i(eret_i),
        .ov_i(ov_i), .adel_if_i(adel_if_i), .adel_i(adel_i), .ades_i(ades_i),
        .bad_addr_i(bad_addr_i),
        .flush_o(flush_o), .newpc_o(newpc_o),
        .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
        .timer_int_o(timer_int_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model kept as individual architectural fields
    logic        m_ie, m_exl, m_bd, m_pend, m_half;
    logic [7:0]  m_im, m_ip;
    logic [4:0]  m_code;
    logic [31:0] m_epc, m_badv, m_count, m_compare;

    // Combinational values sampled in the last cycle
    logic        s_flush;
    logic [31:0] s_npc;

    function automatic logic [31:0] m_status();
        return {9'b0, 1'b1, 6'b0, m_im, 6'b0, m_exl, m_ie};
    endfunction

    function automatic logic [31:0] m_cause();
        return {m_bd, 15'b0, m_ip, 1'b0, m_code, 2'b0};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_badv;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status();
            5'd13:   return m_cause();
            5'd14:   return m_epc;
            5'd15:   return 32'h0000_4220;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_wmask(input logic [4:0] a);
        case (a)
            5'd9, 5'd11: return TIMER_EN ? 32'hFFFF_FFFF : 32'h0;
            5'd12:       return 32'h0000_FF03;
            5'd13:       return 32'h0000_0300;
            5'd14:       return 32'hFFFF_FFFF;
            default:     return 32'h0;
        endcase
    endfunction

    task automatic m_reset();
        m_ie = 0; m_exl = 0; m_bd = 0; m_pend = 0; m_half = 0;
        m_im = 8'hFF; m_ip = 8'h00; m_code = 5'd0;
        m_epc = 0; m_badv = 0; m_count = 0; m_compare = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 0; we_i = 0; waddr_i = 0; wdata_i = 0; raddr_i = 5'd12;
        syscall_i = 0; break_i = 0; reserve_i = 0; eret_i = 0; ov_i = 0;
        adel_if_i = 0; adel_i = 0; ades_i = 0; in_delayslot_i = 0;
        bad_addr_i = 0;
    endtask

    // Called at posedge+1 with inputs set; checks this cycle and the next state.
    task automatic cycle(input string tag);
        logic        irq, exc, flush, cw, pw, adv, npend;
        logic [4:0]  code;
        logic [31:0] npc, exp_rd, nc;
        #3;
        irq  = m_ie && !m_exl && ((m_ip & m_im) != 8'h0);
        exc  = 1'b1;
        code = 5'h00;
        if (irq)            code = 5'h00;
        else if (adel_if_i) code = 5'h04;
        else if (syscall_i) code = 5'h08;
        else if (break_i)   code = 5'h09;
        else if (reserve_i) code = 5'h0A;
        else if (ov_i)      code = 5'h0C;
        else if (adel_i)    code = 5'h04;
        else if (ades_i)    code = 5'h05;
        else                exc  = 1'b0;
        flush = exc || eret_i;
        npc   = exc ? 32'hBFC0_0380 : m_epc;
        exp_rd = m_read(raddr_i);
        if (we_i && waddr_i == raddr_i)
            exp_rd = (exp_rd & ~m_wmask(raddr_i)) | (wdata_i & m_wmask(raddr_i));
        s_flush = flush_o;
        s_npc   = newpc_o;
        chk({tag, ":flush"}, {31'b0, flush_o}, {31'b0, flush});
        if (flush) chk({tag, ":newpc"}, newpc_o, npc);
        chk({tag, ":rdata"}, rdata_o, exp_rd);

        cw  = TIMER_EN && we_i && !flush && waddr_i == 5'd9;
        pw  = TIMER_EN && we_i && !flush && waddr_i == 5'd11;
        adv = cw || m_half;
        nc  = cw ? wdata_i : m_count + {31'b0, m_half};
        npend = pw ? 1'b0 : ((adv && nc == m_compare && m_compare != 0) ? 1'b1 : m_pend);

        if (rst) begin
            m_reset();
        end else begin
            if (exc) begin
                if (!m_exl) begin
                    m_epc = in_delayslot_i ? pc_i - 32'd4 : pc_i;
                    m_bd  = in_delayslot_i;
                end
                m_exl  = 1'b1;
                m_code = code;
                if (!irq && adel_if_i)           m_badv = pc_i;
                else if (code == 5'h04 || code == 5'h05) m_badv = bad_addr_i;
            end else if (eret_i) begin
                m_exl = 1'b0;
            end else if (we_i) begin
                case (waddr_i)
                    5'd12: begin m_im = wdata_i[15:8]; m_exl = wdata_i[1]; m_ie = wdata_i[0]; end
                    5'd13: m_ip[1:0] = wdata_i[9:8];
                    5'd14: m_epc = wdata_i;
                    default: ;
                endcase
            end
            m_ip[7:2] = {hw_int_i[5] | m_pend, hw_int_i[4:0]};
            if (TIMER_EN) begin
                m_count   = nc;
                m_half    = cw ? 1'b0 : ~m_half;
                m_compare = pw ? wdata_i : m_compare;
                m_pend    = npend;
            end
        end

        @(posedge clk);
        #1;
        chk({tag, ":status"}, status_o, m_status());
        chk({tag, ":cause"},  cause_o,  m_cause());
        chk({tag, ":epc"},    epc_o,    m_epc);
        chk({tag, ":timer"},  {31'b0, timer_int_o}, {31'b0, m_pend});
    endtask

    function automatic logic [4:0] pick_addr();
        logic [4:0] tbl [8];
        tbl = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
        return tbl[$urandom_range(0, 7)];
    endfunction

    initial begin
        idle();
        hw_int_i = 0; pc_i = 0;
        m_reset();

        // Reset
        rst = 1;
        @(posedge clk); #1;
        cycle("rst");
        chk("rst_status", status_o, 32'h0040_FF00);
        chk("rst_cause",  cause_o,  32'h0);
        chk("rst_epc",    epc_o,    32'h0);
        chk("rst_flush",  {31'b0, flush_o}, 32'h0);

        // 1: syscall
        idle(); syscall_i = 1; pc_i = 32'h8000_1000;
        cycle("t1");
        chk("t1_flush", {31'b0, s_flush}, 32'h1);
        chk("t1_npc",   s_npc, 32'hBFC0_0380);
        chk("t1_epc",   epc_o, 32'h8000_1000);
        chk("t1_code",  {27'b0, cause_o[6:2]}, 32'h08);
        chk("t1_exl",   {31'b0, status_o[1]}, 32'h1);

        // 2: break in delay slot (after clearing EXL), then ERET
        idle(); eret_i = 1;
        cycle("t2_eret0");
        idle(); break_i = 1; pc_i = 32'h8000_2004; in_delayslot_i = 1;
        cycle("t2_bp");
        chk("t2_epc",  epc_o, 32'h8000_2000);
        chk("t2_bd",   {31'b0, cause_o[31]}, 32'h1);
        chk("t2_code", {27'b0, cause_o[6:2]}, 32'h09);
        idle(); eret_i = 1;
        cycle("t2_eret");
        chk("t2_eflush", {31'b0, s_flush}, 32'h1);
        chk("t2_enpc",   s_npc, 32'h8000_2000);
        chk("t2_eexl",   {31'b0, status_o[1]}, 32'h0);

        // 3: syscall beats overflow; nested exception keeps EPC
        idle(); syscall_i = 1; ov_i = 1; pc_i = 32'h8000_3000;
        cycle("t3_a");
        chk("t3_code", {27'b0, cause_o[6:2]}, 32'h08);
        idle(); syscall_i = 1; ov_i = 1; pc_i = 32'h8000_3100;
        cycle("t3_b");
        chk("t3_epc", epc_o, 32'h8000_3000);

        // 4: hardware interrupt
        idle(); we_i = 1; waddr_i = 5'd12; wdata_i = 32'h0000_0401; hw_int_i = 6'b000001;
        pc_i = 32'h8000_4000;
        cycle("t4_w");
        chk("t4_ip2", {31'b0, cause_o[10]}, 32'h1);
        idle();
        cycle("t4_int");
        chk("t4_flush", {31'b0, s_flush}, 32'h1);
        chk("t4_code",  {27'b0, cause_o[6:2]}, 32'h00);
        idle(); we_i = 1; waddr_i = 5'd12; wdata_i = 32'h0000_0403;
        cycle("t4_w2");
        idle();
        cycle("t4_masked");
        chk("t4_noflush", {31'b0, s_flush}, 32'h0);

        // 5: timer
        idle(); hw_int_i = 0; we_i = 1; waddr_i = 5'd9; wdata_i = 0;
        cycle("t5_cnt");
        idle(); we_i = 1; waddr_i = 5'd11; wdata_i = 5;
        cycle("t5_cmp");
        for (int i = 0; i < 8; i++) begin
            idle(); raddr_i = 5'd9;
            cycle("t5_run");
        end
        chk("t5_not_yet", {31'b0, timer_int_o}, 32'h0);
        idle(); raddr_i = 5'd9;
        cycle("t5_hit");
        chk("t5_rise", {31'b0, timer_int_o}, {31'b0, TIMER_EN});
        idle(); we_i = 1; waddr_i = 5'd11; wdata_i = 100;
        cycle("t5_clr");
        chk("t5_fall", {31'b0, timer_int_o}, 32'h0);

        // 6: MTC0 squashed by ERET; store address error
        idle(); we_i = 1; waddr_i = 5'd14; wdata_i = 32'h1234; eret_i = 1;
        cycle("t6_eret");
        chk("t6_npc", s_npc, 32'h8000_4000);
        chk("t6_epc", epc_o, 32'h8000_4000);
        idle(); ades_i = 1; bad_addr_i = 32'h8000_0003; pc_i = 32'h8000_6000;
        cycle("t6_ades");
        chk("t6_code", {27'b0, cause_o[6:2]}, 32'h05);
        idle(); raddr_i = 5'd8;
        cycle("t6_badv");

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            idle();
            rst            = ($urandom_range(0, 99) == 0);
            we_i           = ($urandom_range(0, 2) == 0);
            waddr_i        = pick_addr();
            wdata_i        = $urandom;
            raddr_i        = ($urandom_range(0, 3) == 0) ? waddr_i : pick_addr();
            hw_int_i       = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'b0;
            pc_i           = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            in_delayslot_i = 1'($urandom);
            syscall_i      = ($urandom_range(0, 15) == 0);
            break_i        = ($urandom_range(0, 15) == 0);
            reserve_i      = ($urandom_range(0, 15) == 0);
            ov_i           = ($urandom_range(0, 15) == 0);
            adel_if_i      = ($urandom_range(0, 15) == 0);
            adel_i         = ($urandom_range(0, 15) == 0);
            ades_i         = ($urandom_range(0, 15) == 0);
            eret_i         = ($urandom_range(0, 5) == 0);
            bad_addr_i     = $urandom;
            cycle("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cp0_exc_unit.md
Name: cp0_exc_unit

Overview:
Coprocessor-0 register file and exception arbiter, sitting at the M/W boundary. It consumes the break/syscall/reserve/eret/cp0we flags that the decoder raises in D, once those flags have been piped down to M. It holds BadVAddr, Count, Compare, Status, Cause, EPC and PRId, and serves MFC0 reads and MTC0 writes. Each cycle it decides whether an exception or ERET is taken, driving a pipeline flush and a redirect PC.

Parameters:
EXC_VECTOR, 32'hBFC00380, redirect target for every exception.
STATUS_RST, 32'h0040FF00, Status reset value (BEV=1, IM=all ones, IE=0, EXL=0).
PRID_VAL, 32'h00004220, constant PRId read value.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
we_i  in  1  MTC0 write strobe (cp0we piped to M)
waddr_i  in  5  CP0 write register number (rd)
wdata_i  in  32  MTC0 data
raddr_i  in  5  MFC0 read register number
rdata_o  out  32  MFC0 read data
hw_int_i  in  6  external interrupt lines, level-sensitive
pc_i  in  32  PC of the M-stage instruction
in_delayslot_i  in  1  M instruction sits in a branch delay slot
syscall_i, break_i, reserve_i, eret_i  in  1 each  decoder flags piped to M
ov_i  in  1  ALU overflow
adel_if_i  in  1  misaligned instruction fetch
adel_i, ades_i  in  1 each  misaligned load / store
bad_addr_i  in  32  faulting data address
flush_o  out  1  flush F..M and redirect
newpc_o  out  32  redirect target (valid when flush_o=1)
status_o, cause_o, epc_o  out  32 each  live register values
timer_int_o  out  1  Count==Compare pending

Behaviour:
- Reset (rst=1 at a clk edge): Status=STATUS_RST; Cause, EPC, BadVAddr, Count and Compare = 0; timer pending = 0; tick toggle = 0. All outputs follow from these registers, so flush_o=0 and timer_int_o=0.
- Cause.IP[7:2] is sampled every cycle from {hw_int_i[5] | timer_pending, hw_int_i[4:0]}. IP[1:0] are software-writable only.
- Interrupt request: Status.IE & ~Status.EXL & |(Cause.IP & Status.IM), where Cause.IP is the current register value.
- Exception priority, highest first, with ExcCode:
  - Int 0x00
  - AdEL-fetch 0x04 (BadVAddr=pc_i)
  - Sys 0x08
  - Bp 0x09
  - RI 0x0A
  - Ov 0x0C
  - AdEL-load 0x04 (BadVAddr=bad_addr_i)
  - AdES 0x05 (BadVAddr=bad_addr_i)
- ERET ranks below all of these and is not an exception.
- Exception taken, combinational in the same cycle: flush_o=1, newpc_o=EXC_VECTOR. At the next edge:
  - Status.EXL=1 and Cause.ExcCode is written.
  - Only if EXL was 0 beforehand: EPC = in_delayslot_i ? pc_i-4 : pc_i, and Cause.BD = in_delayslot_i.
  - If EXL was already 1, EPC and BD are held.
- ERET with no exception: flush_o=1, newpc_o=EPC. At the next edge, Status.EXL=0.
- MTC0 is applied at the edge only when no exception or ERET is taken that cycle.
  - Writable fields: Status IM[15:8], EXL[1], IE[0]; Cause IP[9:8]; EPC; Compare; Count.
  - Writing Compare clears timer_pending.
  - Writes to read-only registers (BadVAddr, PRId) are dropped.
- Count increments by 1 every second clk, using a toggle bit that flips each cycle. An MTC0 to Count loads wdata_i and resets the toggle to 0.
- Wrap-around: Count 0xFFFFFFFF advances to 0 with no flag.
- When an edge makes Count equal Compare and Compare≠0, timer_pending is set. It stays set until Compare is written or reset.
- Read: rdata_o is combinational. If we_i && waddr_i==raddr_i, it bypasses wdata_i (masked to writable fields). Unknown addresses read 0.
- rst asserted mid-exception: reset wins, no EPC capture.

Optional Feature:
COUNT_TIMER_EN.
- Defined: Count/Compare timer exactly as above.
- Undefined: Count and Compare read 0 and ignore writes; timer_pending is tied 0; Cause.IP[7]=hw_int_i[5]; timer_int_o=0.

Decomposition:
- Put in defines.vh:
  - CP0 register numbers: BADVADDR 8, COUNT 9, COMPARE 11, STATUS 12, CAUSE 13, EPC 14, PRID 15.
  - ExcCode constants (EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV).
  - Status/Cause bit-index constants.
- One sub-module, cp0_timer: Count, the tick toggle, Compare and timer_pending, instantiated only under COUNT_TIMER_EN.

Test Plan:
1. rst, then syscall_i=1, pc_i=0x80001000, in_delayslot_i=0 -> same cycle flush_o=1, newpc_o=0xBFC00380. Next cycle EPC=0x80001000, Cause.ExcCode=0x08, Status.EXL=1.
2. break_i=1, pc_i=0x80002004, in_delayslot_i=1 -> EPC=0x80002000, Cause.BD=1, ExcCode=0x09. Then eret_i=1 -> flush_o=1, newpc_o=0x80002000, EXL=0 next cycle.
3. syscall_i=1 and ov_i=1 together -> ExcCode=0x08. Repeat while EXL=1 -> EPC unchanged.
4. MTC0 Status=0x00000401, hw_int_i=6'b000001 -> Cause.IP[2]=1, and the following cycle flush_o=1 with ExcCode=0x00. Same setup with Status.EXL=1 -> no flush.
5. MTC0 Count=0, Compare=5 -> timer_int_o rises after 10 cycles. MTC0 Compare=100 -> timer_int_o falls next cycle.
6. we_i=1, waddr_i=14, wdata_i=0x1234 with eret_i=1 -> write dropped, newpc_o uses the old EPC. ades_i=1, bad_addr_i=0x80000003 -> BadVAddr=0x80000003, ExcCode=0x05.
